// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if -- bus bundle between two requesters (instruction port and
// data port), the arbiter and the shared memory.
//
// Handshake: a requester raises *_req with its fields and holds them stable
// until the cycle its *_gnt is high (grant is combinational in that cycle).
// Dropping *_req before the grant withdraws the request. Every grant returns
// exactly one *_rvalid pulse in the following cycle; *_rdata is valid only
// while its *_rvalid is high.
//
// Signal groups:
//   i_*  instruction port  : i_req, i_addr -> i_gnt, i_rvalid, i_rdata
//   d_*  data port         : d_req, d_we, d_size, d_signed, d_addr, d_wdata
//                            -> d_gnt, d_rvalid, d_err, d_rdata
//   m_*  memory command    : m_we, m_size, m_signed, m_addr, m_wd -> m_rd
//                            (m_rd is valid one cycle after the command)
//
// Modports:
//   slave  - the arbiter (mem_arbiter)
//   master - the environment driving requests and modelling the memory
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int SIZE_LOG2 = 13
);
    // Instruction port
    logic                 i_req;
    logic [SIZE_LOG2-1:0] i_addr;
    logic                 i_gnt;
    logic                 i_rvalid;
    logic [31:0]          i_rdata;

    // Data port
    logic                 d_req;
    logic                 d_we;
    logic [1:0]           d_size;
    logic                 d_signed;
    logic [SIZE_LOG2-1:0] d_addr;
    logic [31:0]          d_wdata;
    logic                 d_gnt;
    logic                 d_rvalid;
    logic                 d_err;
    logic [31:0]          d_rdata;

    // Shared memory command
    logic                 m_we;
    logic [1:0]           m_size;
    logic                 m_signed;
    logic [SIZE_LOG2-1:0] m_addr;
    logic [31:0]          m_wd;
    logic [31:0]          m_rd;

    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata,
        input  d_req, d_we, d_size, d_signed, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_err, d_rdata,
        output m_we, m_size, m_signed, m_addr, m_wd,
        input  m_rd
    );

    modport master (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata,
        output d_req, d_we, d_size, d_signed, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_err, d_rdata,
        input  m_we, m_size, m_signed, m_addr, m_wd,
        output m_rd
    );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter -- shares one single-cycle-latency memory between an
// instruction port (word reads only) and a data port (byte/half/word reads
// and writes). One access per cycle; the response to a grant in cycle N is
// returned in cycle N+1 while a new grant may be issued in cycle N+1.
//
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous reset, active low
//   bus          mem_arbiter_if.slave (requests, grants, responses, memory)
//   dbg_state_o  current FSM state (0 = IDLE, 1 = BUSY)
//
// Configuration macro:
//   MEM_ARB_RR_EN  defined   -> round-robin on simultaneous requests
//                  undefined -> fixed priority, data port wins
//
// Data size encoding: 00 byte, 01 half, 10 word, 11 illegal. An illegal
// data access is granted but never writes memory; its response carries
// d_err=1 and d_rdata=0.
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int SIZE_LOG2 = 13
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus,
    output logic          dbg_state_o
);
    typedef enum logic { IDLE = 1'b0, BUSY = 1'b1 } state_t;
    typedef enum logic { PORT_I = 1'b0, PORT_D = 1'b1 } port_t;

    state_t state_q, state_d;
    // owner_q is the port granted most recently. It also serves as the
    // round-robin pointer: both update on every grant and reset to PORT_I.
    port_t  owner_q, owner_d;
    logic   err_q, err_d;

    logic                 i_gnt_c;
    logic                 d_gnt_c;
    logic                 d_illegal;
    logic                 m_we_c;
    logic [1:0]           m_size_c;
    logic                 m_signed_c;
    logic [SIZE_LOG2-1:0] m_addr_c;
    logic [31:0]          m_wd_c;

    assign d_illegal = (bus.d_size == 2'b11);

    // Grant decision, combinational from this cycle's requests. Nothing is
    // granted while reset is asserted.
    always_comb begin
        i_gnt_c = 1'b0;
        d_gnt_c = 1'b0;
        if (rst) begin
`ifdef MEM_ARB_RR_EN
            if (bus.i_req && bus.d_req) begin
                // Give the contended slot to the port not served last.
                if (owner_q == PORT_I) begin
                    d_gnt_c = 1'b1;
                end else begin
                    i_gnt_c = 1'b1;
                end
            end else begin
                i_gnt_c = bus.i_req;
                d_gnt_c = bus.d_req;
            end
`else
            d_gnt_c = bus.d_req;
            i_gnt_c = bus.i_req && !bus.d_req;
`endif
        end
    end

    // Memory command mux; idle command is a harmless word read of address 0.
    always_comb begin
        m_we_c     = 1'b0;
        m_size_c   = 2'b10;
        m_signed_c = 1'b0;
        m_addr_c   = '0;
        m_wd_c     = 32'd0;
        if (d_gnt_c) begin
            m_we_c     = bus.d_we && !d_illegal;
            m_size_c   = bus.d_size;
            m_signed_c = bus.d_signed;
            m_addr_c   = bus.d_addr;
            m_wd_c     = bus.d_wdata;
        end else if (i_gnt_c) begin
            m_addr_c   = bus.i_addr;
        end
    end

    // Next-state: BUSY for the cycle after any grant.
    always_comb begin
        state_d = (i_gnt_c || d_gnt_c) ? BUSY : IDLE;
        owner_d = owner_q;
        if (d_gnt_c) begin
            owner_d = PORT_D;
        end else if (i_gnt_c) begin
            owner_d = PORT_I;
        end
        err_d = d_gnt_c && d_illegal;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= PORT_I;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            err_q   <= err_d;
        end
    end

    assign bus.i_gnt    = i_gnt_c;
    assign bus.d_gnt    = d_gnt_c;
    assign bus.m_we     = m_we_c;
    assign bus.m_size   = m_size_c;
    assign bus.m_signed = m_signed_c;
    assign bus.m_addr   = m_addr_c;
    assign bus.m_wd     = m_wd_c;

    // Responses are gated by rst so a pending response is suppressed in the
    // very cycle reset is asserted, before the registers clear.
    assign bus.i_rvalid = rst && (state_q == BUSY) && (owner_q == PORT_I);
    assign bus.d_rvalid = rst && (state_q == BUSY) && (owner_q == PORT_D);
    assign bus.d_err    = bus.d_rvalid && err_q;
    assign bus.i_rdata  = bus.m_rd;
    assign bus.d_rdata  = err_q ? 32'd0 : bus.m_rd;

    assign dbg_state_o  = (state_q == BUSY);
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001: Parameter SIZE_LOG2, default 13, byte-address width of the shared memory.
REQ-002: clk  input  1  single clock, all state updates on rising edge.
REQ-003: rst  input  1  reset, synchronous, active-low.
REQ-004: i_req  input  1  instruction port request (word read only).
REQ-005: i_addr  input  SIZE_LOG2  instruction byte address.
REQ-006: i_gnt  output  1  instruction request accepted this cycle.
REQ-007: i_rvalid  output  1  instruction read data valid.
REQ-008: i_rdata  output  32  instruction read data.
REQ-009: d_req  input  1  data port request.
REQ-010: d_we, d_size, d_signed  input  1/2/1  data write enable, size (00 byte, 01 half, 10 word, 11 illegal), sign-extend.
REQ-011: d_addr, d_wdata  input  SIZE_LOG2/32  data byte address, write data.
REQ-012: d_gnt, d_rvalid, d_err  output  1/1/1  data accepted; response valid (reads and writes); illegal-size flag.
REQ-013: d_rdata  output  32  data read data.
REQ-014: m_we, m_size, m_signed, m_addr, m_wd  output  1/2/1/SIZE_LOG2/32  shared memory command.
REQ-015: m_rd  input  32  shared memory read data, valid one cycle after command.

Function
REQ-016: Grant is combinational from requests in the same cycle; at most one of i_gnt/d_gnt high per cycle.
REQ-017: Requester holds req and all fields stable until its gnt; dropping req before gnt is a legal withdraw.
REQ-018: On grant, the granted port's fields drive m_* in that same cycle; instruction grant drives m_we=0, m_size=10, m_signed=0.
REQ-019: No grant: m_we=0, m_size=10, m_addr=0, m_wd=0.
REQ-020: FSM states IDLE, BUSY; IDLE->BUSY on any grant; BUSY->BUSY on grant; BUSY->IDLE with no grant.
REQ-021: Owner register records granted port and error flag each grant.
REQ-022: In BUSY, exactly one rvalid pulses for one cycle to the recorded owner; rdata = m_rd for that cycle.
REQ-023: Throughput one access per cycle: a new grant is allowed in the same cycle as the previous response.
REQ-024: d_size=11 with d_req: d_gnt asserted, m_we forced 0, next cycle d_rvalid=1, d_err=1, d_rdata=0.
REQ-025: d_err is 0 whenever d_rvalid is 0 or the access was legal.
REQ-026: Unaligned addresses passed through unchanged; alignment and wrap are handled by the memory.
REQ-027: Write responses: d_rvalid pulses next cycle, d_rdata don't-care, d_err=0.
REQ-028: i_rdata/d_rdata hold m_rd combinationally; only meaningful while their rvalid is high.

Reset
REQ-029: While rst=0: FSM to IDLE, i_gnt=d_gnt=0, i_rvalid=d_rvalid=d_err=0, m_we=0, owner and RR pointer to instruction port.
REQ-030: Reset asserted with a response pending discards it; no rvalid on the cycle after rst returns high.
REQ-031: First grant possible in the first cycle with rst=1.

Configuration
REQ-032: Macro MEM_ARB_RR_EN defined: round-robin; on simultaneous requests grant the port not granted last; pointer updates only on grant.
REQ-033: Macro MEM_ARB_RR_EN undefined: fixed priority, data port always wins simultaneous requests; no pointer state.

Verification
REQ-034: Only i_req=1, i_addr=0x010, memory word 0x11223344 -> i_gnt same cycle, i_rvalid next cycle, i_rdata=0x11223344.
REQ-035: d_req write d_size=00 d_addr=0x003 d_wdata=0xAB, then read d_size=00 d_signed=1 -> second d_rvalid with d_rdata=0xFFFFFFAB, d_err=0.
REQ-036: Both requests held 4 cycles -> with MEM_ARB_RR_EN grants D,I,D,I (pointer at I after reset); without: D,D,D,D, i_gnt=0.
REQ-037: d_size=11, d_we=1 -> m_we=0, next cycle d_rvalid=1, d_err=1, memory unchanged.
REQ-038: Grant in cycle N, rst=0 in cycle N+1 -> no rvalid in N+1 or N+2, all outputs at reset values.
REQ-039: Back-to-back data reads at 0x000,0x004,0x008 -> d_rvalid high three consecutive cycles with matching data in order.
